// File: rtl/issue_queue_mw.sv
// Multi-lane, age-ordered compacting issue queue with wakeup, dispatch bypass,
// credit-style free_count and flush. Entry 0 is always the oldest resident op.
module issue_queue_mw #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int DEPTH          = 8,
  parameter int WAKEUP_WIDTH   = 2,
  parameter int PREG_W         = 6,
  parameter int CMD_W          = 5,
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [DISPATCH_WIDTH-1:0]        disp_en,
  input  logic [DISPATCH_WIDTH*CMD_W-1:0]  disp_alu_cmd,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0] disp_op1,
  input  logic [DISPATCH_WIDTH-1:0]        disp_op1_valid,
  input  logic [DISPATCH_WIDTH*32-1:0]     disp_op2,
  input  logic [DISPATCH_WIDTH-1:0]        disp_op2_type,
  input  logic [DISPATCH_WIDTH-1:0]        disp_op2_valid,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0] disp_phys_rd,
  output logic [CNT_W-1:0]                 free_count,
  output logic                             overflow_err,
  input  logic [WAKEUP_WIDTH-1:0]          wakeup_valid,
  input  logic [WAKEUP_WIDTH*PREG_W-1:0]   wakeup_tag,
  output logic [ISSUE_WIDTH-1:0]           issue_valid,
  input  logic [ISSUE_WIDTH-1:0]           issue_ready,
  output logic [ISSUE_WIDTH*CMD_W-1:0]     issue_alu_cmd,
  output logic [ISSUE_WIDTH*PREG_W-1:0]    issue_op1,
  output logic [ISSUE_WIDTH*32-1:0]        issue_op2,
  output logic [ISSUE_WIDTH-1:0]           issue_op2_type,
  output logic [ISSUE_WIDTH*PREG_W-1:0]    issue_phys_rd
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              valid_q   [DEPTH];
  logic [CMD_W-1:0]  cmd_q     [DEPTH];
  logic [PREG_W-1:0] op1_q     [DEPTH];
  logic              op1_rdy_q [DEPTH];
  logic [31:0]       op2_q     [DEPTH];
  logic              op2_imm_q [DEPTH];
  logic              op2_rdy_q [DEPTH];
  logic [PREG_W-1:0] rd_q      [DEPTH];

  logic              valid_n   [DEPTH];
  logic [CMD_W-1:0]  cmd_n     [DEPTH];
  logic [PREG_W-1:0] op1_n     [DEPTH];
  logic              op1_rdy_n [DEPTH];
  logic [31:0]       op2_n     [DEPTH];
  logic              op2_imm_n [DEPTH];
  logic              op2_rdy_n [DEPTH];
  logic [PREG_W-1:0] rd_n      [DEPTH];

  logic [DEPTH-1:0]       entry_rdy;
  logic [DEPTH-1:0]       remove;
  logic [ISSUE_WIDTH-1:0] sel_valid;
  logic [IDX_W-1:0]       sel_idx [ISSUE_WIDTH];
  logic [CNT_W-1:0]       n_count;
  logic                   drop;

  // Select: lane j takes the j-th ready entry counted from the oldest.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      sel_valid[j] = 1'b0;
      sel_idx[j]   = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      entry_rdy[i] = valid_q[i] & op1_rdy_q[i] & op2_rdy_q[i];
      if (entry_rdy[i]) begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
          if (cnt == j) begin
            sel_valid[j] = 1'b1;
            sel_idx[j]   = IDX_W'(i);
          end
        end
        cnt = cnt + 1;
      end
    end
  end

  always_comb begin
    issue_valid    = sel_valid;
    issue_alu_cmd  = '0;
    issue_op1      = '0;
    issue_op2      = '0;
    issue_op2_type = '0;
    issue_phys_rd  = '0;
    remove         = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      issue_alu_cmd[j*CMD_W +: CMD_W]   = cmd_q[sel_idx[j]];
      issue_op1[j*PREG_W +: PREG_W]     = op1_q[sel_idx[j]];
      issue_op2[j*32 +: 32]             = op2_q[sel_idx[j]];
      issue_op2_type[j]                 = op2_imm_q[sel_idx[j]];
      issue_phys_rd[j*PREG_W +: PREG_W] = rd_q[sel_idx[j]];
      if (sel_valid[j] && issue_ready[j])
        remove[sel_idx[j]] = 1'b1;
    end
  end

  // Next state: compact survivors, append dispatch, then apply wakeup to
  // everything, which also covers the same-cycle dispatch bypass.
  always_comb begin
    int k;
    int a;
    logic [IDX_W-1:0] pos;
    k    = 0;
    a    = 0;
    pos  = '0;
    drop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_n[i]   = 1'b0;
      cmd_n[i]     = '0;
      op1_n[i]     = '0;
      op1_rdy_n[i] = 1'b0;
      op2_n[i]     = '0;
      op2_imm_n[i] = 1'b0;
      op2_rdy_n[i] = 1'b0;
      rd_n[i]      = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !remove[i]) begin
        pos            = IDX_W'(k);
        valid_n[pos]   = 1'b1;
        cmd_n[pos]     = cmd_q[i];
        op1_n[pos]     = op1_q[i];
        op1_rdy_n[pos] = op1_rdy_q[i];
        op2_n[pos]     = op2_q[i];
        op2_imm_n[pos] = op2_imm_q[i];
        op2_rdy_n[pos] = op2_rdy_q[i];
        rd_n[pos]      = rd_q[i];
        k = k + 1;
      end
    end
    // Acceptance is limited by the registered credit, not by this edge's issues.
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (disp_en[l]) begin
        if (a < int'(free_count) && (k + a) < DEPTH) begin
          pos            = IDX_W'(k + a);
          valid_n[pos]   = 1'b1;
          cmd_n[pos]     = disp_alu_cmd[l*CMD_W +: CMD_W];
          op1_n[pos]     = disp_op1[l*PREG_W +: PREG_W];
          op1_rdy_n[pos] = disp_op1_valid[l];
          op2_n[pos]     = disp_op2[l*32 +: 32];
          op2_imm_n[pos] = disp_op2_type[l];
          op2_rdy_n[pos] = disp_op2_type[l] | disp_op2_valid[l];
          rd_n[pos]      = disp_phys_rd[l*PREG_W +: PREG_W];
          a = a + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int w = 0; w < WAKEUP_WIDTH; w++) begin
        if (valid_n[i] && wakeup_valid[w]) begin
          if (op1_n[i] == wakeup_tag[w*PREG_W +: PREG_W])
            op1_rdy_n[i] = 1'b1;
          if (!op2_imm_n[i] && op2_n[i][PREG_W-1:0] == wakeup_tag[w*PREG_W +: PREG_W])
            op2_rdy_n[i] = 1'b1;
        end
      end
    end
    n_count = CNT_W'(k + a);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      free_count   <= CNT_W'(DEPTH);
      overflow_err <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      free_count <= CNT_W'(DEPTH);
    end else begin
      valid_q      <= valid_n;
      cmd_q        <= cmd_n;
      op1_q        <= op1_n;
      op1_rdy_q    <= op1_rdy_n;
      op2_q        <= op2_n;
      op2_imm_q    <= op2_imm_n;
      op2_rdy_q    <= op2_rdy_n;
      rd_q         <= rd_n;
      free_count   <= CNT_W'(DEPTH) - n_count;
      overflow_err <= overflow_err | drop;
    end
  end

endmodule
